// File: rtl/acc_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : acc_write_queue
// Purpose  : FIFO write-back buffer in front of the accumulator bank, with
//            forwarding lookup of values that are still pending.
// Revision : 1.0
// ============================================================================
module acc_write_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BITS   = 2,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [REG_BITS-1:0]     inRegister,
    input  logic [DATA_WIDTH-1:0]   inData,
    input  logic                    holdWrite,
    output logic                    regWrite,
    output logic [REG_BITS-1:0]     RegisterNumber,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [REG_BITS-1:0]     lookupRegister,
    output logic                    lookupHit,
    output logic [DATA_WIDTH-1:0]   lookupData,
    output logic [$clog2(DEPTH):0]  pendingCount,
    output logic                    overflowFlag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_BITS-1:0]   reg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic [PTR_W-1:0]      scan_idx;

    // A full queue refuses input even if it drains this cycle.
    always_comb begin
        inReady = resetN && (count < CNT_W'(DEPTH));
        push    = inValid && inReady;
        pop     = (count != '0) && !holdWrite;
    end

    assign pendingCount = count;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            regWrite       <= 1'b0;
            RegisterNumber <= '0;
            writeData      <= '0;
            overflowFlag   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                regWrite       <= 1'b1;
                RegisterNumber <= reg_mem[rd_ptr];
                writeData      <= data_mem[rd_ptr];
            end else begin
                regWrite <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (inValid && !inReady) begin
                overflowFlag <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        if (push) begin
            reg_mem[wr_ptr]  <= inRegister;
            data_mem[wr_ptr] <= inData;
        end
    end

    // Scan oldest to newest so the newest queued match wins over the output stage.
    always_comb begin
        lookupHit  = 1'b0;
        lookupData = '0;
        scan_idx   = '0;
        if (regWrite && (RegisterNumber == lookupRegister)) begin
            lookupHit  = 1'b1;
            lookupData = writeData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (reg_mem[scan_idx] == lookupRegister)) begin
                lookupHit  = 1'b1;
                lookupData = data_mem[scan_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_write_queue
// Purpose  : Scoreboard bench for acc_write_queue (directed vectors).
// Revision : 1.0
// ============================================================================
module tb_acc_write_queue;

    logic       clock = 1'b0;
    logic       resetN;
    logic       inValid;
    logic       inReady;
    logic [1:0] inRegister;
    logic [7:0] inData;
    logic       holdWrite;
    logic       regWrite;
    logic [1:0] RegisterNumber;
    logic [7:0] writeData;
    logic [1:0] lookupRegister;
    logic       lookupHit;
    logic [7:0] lookupData;
    logic [2:0] pendingCount;
    logic       overflowFlag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] sb[$];

    acc_write_queue #(.DATA_WIDTH(8), .REG_BITS(2), .DEPTH(4)) dut (
        .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .inRegister(inRegister), .inData(inData), .holdWrite(holdWrite),
        .regWrite(regWrite), .RegisterNumber(RegisterNumber), .writeData(writeData),
        .lookupRegister(lookupRegister), .lookupHit(lookupHit), .lookupData(lookupData),
        .pendingCount(pendingCount), .overflowFlag(overflowFlag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (resetN && regWrite) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got reg=%0d data=0x%02h, expected no write",
                         RegisterNumber, writeData);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                if ({RegisterNumber, writeData} != e) begin
                    n_fail++;
                    $display("FAIL wr_order: got reg=%0d data=0x%02h, expected reg=%0d data=0x%02h",
                             RegisterNumber, writeData, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic push(input logic [1:0] r, input logic [7:0] d, input bit accept);
        inValid    = 1'b1;
        inRegister = r;
        inData     = d;
        if (accept) sb.push_back({r, d});
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((sb.size() != 0 || pendingCount != 0) && c < 40) begin
            @(posedge clock);
            c++;
        end
        repeat (2) @(posedge clock);
        #1;
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0; inValid = 1'b0; inRegister = '0; inData = '0;
        holdWrite = 1'b0; lookupRegister = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_inReady", inReady, 0);
        chk("rst_count", pendingCount, 0);
        chk("rst_regWrite", regWrite, 0);
        chk("rst_overflow", overflowFlag, 0);
        chk("rst_wdata", writeData, 0);
        resetN = 1'b1;
        #1;
        chk("rel_inReady", inReady, 1);

        // Single write: two-edge latency, one-cycle pulse
        push(2'd1, 8'h03, 1);
        chk("t1_no_bypass", regWrite, 0);
        chk("t1_count1", pendingCount, 1);
        @(posedge clock); #1;
        chk("t1_pulse", regWrite, 1);
        chk("t1_count0", pendingCount, 0);
        @(posedge clock); #1;
        chk("t1_pulse_end", regWrite, 0);

        // Fill, back-pressure, overflow
        holdWrite = 1'b1;
        for (int i = 0; i < 4; i++) push(2'(i), 8'h10 + 8'(i), 1);
        chk("t2_count4", pendingCount, 4);
        chk("t2_full_ready", inReady, 0);
        push(2'd0, 8'h14, 0);
        chk("t2_overflow", overflowFlag, 1);
        chk("t2_count_hold", pendingCount, 4);
        chk("t2_no_write", regWrite, 0);
        holdWrite = 1'b0;
        wait_drain("t2_drain");

        // Back-to-back stream with pointer wrap
        for (int i = 0; i < 10; i++) begin
            inValid    = 1'b1;
            inRegister = 2'(i % 4);
            inData     = 8'(i);
            sb.push_back({2'(i % 4), 8'(i)});
            @(posedge clock); #1;
            chk("t3_count_le1", int'(pendingCount <= 1), 1);
        end
        inValid = 1'b0;
        wait_drain("t3_drain");

        // Forwarding priority among queued entries
        holdWrite = 1'b1;
        push(2'd2, 8'h05, 1);
        push(2'd2, 8'h07, 1);
        lookupRegister = 2'd2; #1;
        chk("t4_hit", lookupHit, 1);
        chk("t4_newest", lookupData, 8'h07);
        lookupRegister = 2'd3; #1;
        chk("t4_miss", lookupHit, 0);
        chk("t4_miss_data", lookupData, 0);
        holdWrite = 1'b0;
        wait_drain("t4_drain");

        // Output-stage forwarding
        lookupRegister = 2'd3;
        push(2'd3, 8'h2A, 1);
        chk("t5_q_hit", lookupHit, 1);
        @(posedge clock); #1;
        chk("t5_pulse", regWrite, 1);
        chk("t5_os_hit", lookupHit, 1);
        chk("t5_os_data", lookupData, 8'h2A);
        @(posedge clock); #1;
        chk("t5_after_hit", lookupHit, 0);
        chk("t5_after_data", lookupData, 0);

        // Reset mid-operation discards queued entries
        holdWrite = 1'b1;
        push(2'd0, 8'hA0, 0);
        push(2'd1, 8'hA1, 0);
        push(2'd2, 8'hA2, 0);
        chk("t6_count3", pendingCount, 3);
        resetN = 1'b0; #1;
        chk("t6_rst_ready", inReady, 0);
        @(posedge clock); #1;
        chk("t6_count0", pendingCount, 0);
        chk("t6_regWrite", regWrite, 0);
        chk("t6_overflow", overflowFlag, 0);
        resetN = 1'b1; #1;
        chk("t6_ready", inReady, 1);
        holdWrite = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("t6_no_writes", sb.size(), 0);
        chk("t6_idle_count", pendingCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_write_queue.md
Name: acc_write_queue

Overview:
Write-back stage sitting directly upstream of the accumulator register bank. Accepts ALU results (target register + 8-bit value) over a valid/ready handshake and buffers them in a small FIFO. Drains them into the bank as single-cycle regWrite/RegisterNumber/writeData pulses. Provides a combinational forwarding lookup so readers see values still queued and not yet written.

Parameters:
DATA_WIDTH, 8, width of writeData / queued values
REG_BITS, 2, width of RegisterNumber (4 accumulator registers)
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clock  input  1  rising-edge clock
resetN  input  1  synchronous active-low reset
inValid  input  1  upstream result valid
inReady  output  1  queue can accept this cycle
inRegister  input  REG_BITS  target register of incoming result
inData  input  DATA_WIDTH  incoming result value
holdWrite  input  1  when 1, no entry is drained this cycle
regWrite  output  1  write strobe to accumulator bank (registered)
RegisterNumber  output  REG_BITS  register index to bank (registered)
writeData  output  DATA_WIDTH  data to bank (registered)
lookupRegister  input  REG_BITS  register being read by consumer
lookupHit  output  1  a pending value exists for lookupRegister
lookupData  output  DATA_WIDTH  newest pending value for lookupRegister
pendingCount  output  log2(DEPTH)+1  entries currently queued
overflowFlag  output  1  sticky: push attempted while not ready

Behaviour:
- Reset (resetN=0 at rising edge): count=0, read/write pointers=0, regWrite=0, RegisterNumber=0, writeData=0, overflowFlag=0. Queued entries are discarded. inReady=0 while resetN=0.
- inReady = resetN && (count < DEPTH). Combinational from registered count. A full queue does not accept, even if it drains in the same cycle.
- Push: at an edge with inValid && inReady, {inRegister, inData} is written at the tail and the write pointer increments mod DEPTH.
- Pop condition (pre-edge state): count > 0 && !holdWrite.
  - If true at an edge: regWrite<=1, RegisterNumber<=head register, writeData<=head data; the read pointer increments mod DEPTH.
  - Otherwise: regWrite<=0; RegisterNumber and writeData hold their values.
- Latency: an entry pushed at edge k into an empty queue drives regWrite high after edge k+1. The bank captures it at edge k+2. No same-cycle bypass from input to output.
- Simultaneous push and pop: count unchanged. Pointers both advance. Order is preserved (strict FIFO, no coalescing of same-register writes).
- Pointers wrap at DEPTH. count runs 0..DEPTH and never wraps.
- holdWrite does not cancel a regWrite already asserted. That pulse completes, and regWrite drops at the next edge.
- Forwarding (combinational):
  - lookupHit=1 if any queued entry has a matching register, or if regWrite=1 and RegisterNumber==lookupRegister.
  - lookupData priority: newest matching queued entry (closest to tail), then the output-stage value.
  - When lookupHit=0, lookupData=0.
- overflowFlag: set at any edge with inValid && !inReady && resetN. Cleared only by reset. The offered data is dropped.
- pendingCount = count. The output-stage entry is not included.

Test Plan:
- Reset then single write: push (reg1, 0x03) at edge 1 -> regWrite=1, RegisterNumber=1, writeData=0x03 for exactly one cycle after edge 2; pendingCount returns to 0.
- Fill and back-pressure: holdWrite=1, push reg0..3 values 0x10,0x11,0x12,0x13 -> pendingCount=4, inReady=0. A 5th push (0x14) sets overflowFlag=1 and is dropped. Release holdWrite -> four consecutive regWrite pulses 0x10..0x13 in order; 0x14 never appears.
- Simultaneous push/pop with wrap: stream 10 back-to-back pushes (reg i%4, value i) with holdWrite=0 -> pendingCount stays <=1, outputs appear in order 0..9, pointers wrap without loss.
- Forwarding priority: holdWrite=1, push (reg2,0x05) then (reg2,0x07), lookupRegister=2 -> lookupHit=1, lookupData=0x07. lookupRegister=3 -> lookupHit=0, lookupData=0.
- Output-stage forwarding: single entry (reg3,0x2A) popped -> while regWrite=1, lookupRegister=3 gives lookupHit=1, lookupData=0x2A. The next cycle gives lookupHit=0.
- Reset mid-operation: 3 entries queued, resetN=0 for one edge -> pendingCount=0, regWrite=0, overflowFlag=0, no further writes emitted; inReady=1 after resetN returns high.
